// File: rtl/switch_conditioner.sv
// Slide-switch front end for the LED chaser: synchronise, debounce, edge pulses,
// plus a free-running step strobe and a tick-aligned direction bit.
module switch_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_DIV    = 524288
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iSW,
  output logic oSW,
  output logic oSW_RISE,
  output logic oSW_FALL,
  output logic oTICK,
  output logic oDIR
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_t             state_q, state_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   sw_q, sw_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  logic [PRE_W-1:0]       presc_q, presc_d;
  logic                   tick_q, tick_d;
  logic                   dir_q, dir_d;

  // Only sync_q[0] ever looks at the asynchronous switch.
  always_ff @(posedge iCLK) begin
    if (iRST) sync_q[0] <= 1'b0;
    else      sync_q[0] <= iSW;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge iCLK) begin
        if (iRST) sync_q[gi] <= 1'b0;
        else      sync_q[gi] <= sync_q[gi-1];
      end
    end
  endgenerate

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= STABLE_LO;
      deb_cnt_q <= '0;
      sw_q      <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      dir_q     <= dir_d;
    end
  end

  // The count is the number of consecutive edges that sampled s at the new level.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    sw_d      = sw_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d   = WAIT_HI;
          deb_cnt_d = DEB_W'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d   = STABLE_LO;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = STABLE_HI;
          deb_cnt_d = '0;
          sw_d      = 1'b1;
          rise_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d   = WAIT_LO;
          deb_cnt_d = DEB_W'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d   = STABLE_HI;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = STABLE_LO;
          deb_cnt_d = '0;
          sw_d      = 1'b0;
          fall_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d   = STABLE_LO;
        deb_cnt_d = '0;
      end
    endcase
  end

  // tick_q is registered from the next prescaler value so it lines up with presc==LAST.
  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    tick_d  = (presc_d == PRE_LAST);
    dir_d   = tick_q ? sw_d : dir_q;
  end

  assign oSW      = sw_q;
  assign oSW_RISE = rise_q;
  assign oSW_FALL = fall_q;
  assign oTICK    = tick_q;
  assign oDIR     = dir_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: stimulus pushes expected events,
// a monitor sampling 2 ns after each rising edge pops and compares them.
module tb_switch_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DIV  = 8;
  localparam int LAT  = SYNC + DEB;

  typedef struct {
    int   edge_n;
    logic val;
  } exp_t;

  logic clk;
  logic iRST;
  logic iSW;
  logic oSW, oSW_RISE, oSW_FALL, oTICK, oDIR;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic rst_seen = 1'b1;
  int   rst_rel = 0;

  exp_t ev_q[$];
  exp_t dir_q[$];
  int   tick_q[$];

  logic mon_sw  = 1'b0;
  logic mon_dir = 1'b0;
  exp_t mon_e;

  switch_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .TICK_DIV   (DIV)
  ) dut (
    .iCLK    (clk),
    .iRST    (iRST),
    .iSW     (iSW),
    .oSW     (oSW),
    .oSW_RISE(oSW_RISE),
    .oSW_FALL(oSW_FALL),
    .oTICK   (oTICK),
    .oDIR    (oDIR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_seen <= iRST;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, edge_cnt, act, exp_v);
    end
  endtask

  // Edge at which oDIR should take value of an oSW change landing at edge e.
  function automatic int dir_edge(input int e);
    int t;
    int first;
    t     = e - 1;
    first = rst_rel + DIV - 1;
    if (t <= first) return first + 1;
    return first + ((t - first + DIV - 1) / DIV) * DIV + 1;
  endfunction

  task automatic push_expect(input int e, input logic v);
    exp_t x;
    x.edge_n = e;
    x.val    = v;
    ev_q.push_back(x);
    x.edge_n = dir_edge(e);
    dir_q.push_back(x);
  endtask

  // Called at a falling edge.
  task automatic set_sw(input logic v);
    iSW = v;
    push_expect(edge_cnt + LAT, v);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    iRST = 1'b1;
    tick_q.delete();
    dir_q.delete();
    wait_cycles(n);
    iRST    = 1'b0;
    rst_rel = edge_cnt;
    for (int k = 0; k < 200; k++) tick_q.push_back(rst_rel + DIV - 1 + DIV * k);
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_seen) begin
      chk("reset_outputs", int'({oSW, oSW_RISE, oSW_FALL, oTICK, oDIR}), 0);
      mon_sw  = 1'b0;
      mon_dir = 1'b0;
    end else begin
      if (ev_q.size() > 0 && ev_q[0].edge_n == edge_cnt) begin
        mon_e = ev_q.pop_front();
        chk("sw_level", int'(oSW), int'(mon_e.val));
        chk("rise_pulse", int'(oSW_RISE), int'(mon_e.val));
        chk("fall_pulse", int'(oSW_FALL), int'(!mon_e.val));
        mon_sw = mon_e.val;
        $display("edge %0d: switch %s, oSW=%0b", edge_cnt, mon_e.val ? "rise" : "fall", oSW);
      end else begin
        chk("sw_hold", int'(oSW), int'(mon_sw));
        chk("no_pulse", int'({oSW_RISE, oSW_FALL}), 0);
      end
      if (tick_q.size() > 0 && tick_q[0] == edge_cnt) begin
        void'(tick_q.pop_front());
        chk("tick", int'(oTICK), 1);
        $display("edge %0d: tick (%0d after reset), oDIR=%0b", edge_cnt, edge_cnt - rst_rel, oDIR);
      end else begin
        chk("no_tick", int'(oTICK), 0);
      end
      if (dir_q.size() > 0 && dir_q[0].edge_n == edge_cnt) begin
        mon_e = dir_q.pop_front();
        chk("dir_update", int'(oDIR), int'(mon_e.val));
        mon_dir = mon_e.val;
        $display("edge %0d: direction -> %0b", edge_cnt, oDIR);
      end else begin
        chk("dir_hold", int'(oDIR), int'(mon_dir));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d actual=timeout expected=finish", edge_cnt);
    $fatal(1);
  end

  initial begin
    iRST = 1'b1;
    iSW  = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles with the switch already high.
    do_reset(3);
    push_expect(rst_rel + LAT, 1'b1);
    wait_cycles(20);

    // Clean toggles.
    set_sw(1'b0);
    wait_cycles(20);
    set_sw(1'b1);
    wait_cycles(20);
    set_sw(1'b0);
    wait_cycles(20);

    // Bounce runs 1,3,2,3 then settle high.
    iSW = 1'b1; wait_cycles(1);
    iSW = 1'b0; wait_cycles(3);
    iSW = 1'b1; wait_cycles(2);
    iSW = 1'b0; wait_cycles(3);
    set_sw(1'b1);
    wait_cycles(20);
    set_sw(1'b0);
    wait_cycles(20);

    // Reset in the middle of a debounce count.
    iSW = 1'b1;
    wait_cycles(4);
    do_reset(1);
    push_expect(rst_rel + LAT, 1'b1);
    wait_cycles(20);
    set_sw(1'b0);
    wait_cycles(20);

    // oSW rises at cycle 10; direction follows after the tick at cycle 15.
    do_reset(1);
    wait_cycles(4);
    set_sw(1'b1);
    wait_cycles(20);
    set_sw(1'b0);
    wait_cycles(20);

    // oSW changes on the edge that closes the first tick cycle.
    do_reset(1);
    wait_cycles(2);
    set_sw(1'b1);
    wait_cycles(40);

    chk("events_drained", ev_q.size(), 0);
    chk("dir_drained", dir_q.size(), 0);
    chk("ticks_drained", int'(tick_q.size() > 0 && tick_q[0] <= edge_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
